// File: rtl/set_less_than_seq.sv
// Multi-cycle set-less-than: compares A against B MSB-first, CHUNK bits per cycle, stopping at the first unequal chunk.
// Latency k cycles from accept (k = chunks examined); result held until iReady, no accept in that same cycle.
module set_less_than_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iDataA,
    input  logic [WIDTH-1:0] iDataB,
    input  logic [1:0]       iMode,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oData,
    output logic [2:0]       oSet
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_inv;
    logic [IDXW-1:0]  r_idx;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [2:0]       r_set;

    int               w_off;
    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic             w_lt;
    logic             w_gt;
    logic             w_last;

    always_comb begin
        w_off  = int'(r_idx) * CHUNK;
        w_ca   = r_a[w_off +: CHUNK];
        w_cb   = r_b[w_off +: CHUNK];
        w_lt   = (w_ca < w_cb);
        w_gt   = (w_ca > w_cb);
        w_last = (r_idx == '0);
    end

    assign oReady = (r_state == S_IDLE) && !iRst;
    assign oValid = r_valid;
    assign oData  = r_data;
    assign oSet   = r_set;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_inv   <= 1'b0;
            r_idx   <= LAST_IDX;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_set   <= 3'b000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iValid) begin
                        // Flipping the sign bit maps signed order onto unsigned order.
                        r_a     <= {iDataA[WIDTH-1] ^ iMode[0], iDataA[WIDTH-2:0]};
                        r_b     <= {iDataB[WIDTH-1] ^ iMode[0], iDataB[WIDTH-2:0]};
                        r_inv   <= iMode[1];
                        r_idx   <= LAST_IDX;
                        r_state <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (w_lt || w_gt || w_last) begin
                        r_set   <= {w_lt, !w_lt && !w_gt, w_gt};
                        r_data  <= WIDTH'(r_inv ^ w_lt);
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                S_DONE: begin
                    if (iReady) begin
                        r_valid <= 1'b0;
                        r_set   <= 3'b000;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_set_less_than_seq.sv
// Directed bench for set_less_than_seq: 32/8 and 64/16 instances, hand-computed expectations.
module tb_set_less_than_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v32 = 1'b0;
    logic        v64 = 1'b0;
    logic        rdy = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] a32 = '0, b32 = '0;
    logic [63:0] a64 = '0, b64 = '0;

    logic        o_ready32, o_valid32, o_ready64, o_valid64;
    logic [31:0] o_data32;
    logic [63:0] o_data64;
    logic [2:0]  o_set32, o_set64;

    int chk_cnt = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    set_less_than_seq #(.WIDTH(32), .CHUNK(8)) dut32 (
        .iClk(clk), .iRst(rst), .iValid(v32), .oReady(o_ready32),
        .iDataA(a32), .iDataB(b32), .iMode(mode), .oValid(o_valid32),
        .iReady(rdy), .oData(o_data32), .oSet(o_set32)
    );

    set_less_than_seq #(.WIDTH(64), .CHUNK(16)) dut64 (
        .iClk(clk), .iRst(rst), .iValid(v64), .oReady(o_ready64),
        .iDataA(a64), .iDataB(b64), .iMode(mode), .oValid(o_valid64),
        .iReady(rdy), .oData(o_data64), .oSet(o_set64)
    );

    // Called #1 after an edge with the target idle; returns edges from accept to oValid, or -1.
    task automatic issue(input bit wide, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] m, output int lat);
        mode = m;
        if (wide) begin a64 = a; b64 = b; v64 = 1'b1; end
        else begin a32 = a[31:0]; b32 = b[31:0]; v32 = 1'b1; end
        @(posedge clk); #1;
        v32 = 1'b0;
        v64 = 1'b0;
        lat = 0;
        while (!(wide ? o_valid64 : o_valid32) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!(wide ? o_valid64 : o_valid32)) lat = -1;
    endtask

    task automatic release_result();
        rdy = 1'b1;
        @(posedge clk); #1;
        rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++; if (o_ready32 !== 1'b0) $display("FAIL reset_ready_high got %b exp 0", o_ready32); else pass_cnt++;
        chk_cnt++; if (o_valid32 !== 1'b0) $display("FAIL reset_valid got %b exp 0", o_valid32); else pass_cnt++;
        chk_cnt++; if (o_data32 !== 32'h0) $display("FAIL reset_data got %h exp 0", o_data32); else pass_cnt++;
        chk_cnt++; if (o_set32 !== 3'b000) $display("FAIL reset_set got %b exp 000", o_set32); else pass_cnt++;
        rst = 1'b0;
        #1;
        chk_cnt++; if (o_ready32 !== 1'b1) $display("FAIL reset_ready_after got %b exp 1", o_ready32); else pass_cnt++;
        chk_cnt++; if (o_ready64 !== 1'b1) $display("FAIL reset_ready64_after got %b exp 1", o_ready64); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_sltu_slt();
        int lat;
        issue(1'b0, 64'h1, 64'hFFFF_FFFF, 2'b00, lat);
        chk_cnt++; if (lat !== 1) $display("FAIL sltu_lat got %0d exp 1", lat); else pass_cnt++;
        chk_cnt++; if (o_data32 !== 32'h1) $display("FAIL sltu_data got %h exp 1", o_data32); else pass_cnt++;
        chk_cnt++; if (o_set32 !== 3'b100) $display("FAIL sltu_set got %b exp 100", o_set32); else pass_cnt++;
        release_result();
        issue(1'b0, 64'h1, 64'hFFFF_FFFF, 2'b01, lat);
        chk_cnt++; if (lat !== 1) $display("FAIL slt_lat got %0d exp 1", lat); else pass_cnt++;
        chk_cnt++; if (o_data32 !== 32'h0) $display("FAIL slt_data got %h exp 0", o_data32); else pass_cnt++;
        chk_cnt++; if (o_set32 !== 3'b001) $display("FAIL slt_set got %b exp 001", o_set32); else pass_cnt++;
        release_result();
    endtask

    task automatic test_equal_and_ge();
        int lat;
        issue(1'b0, 64'h1234_5678, 64'h1234_5678, 2'b01, lat);
        chk_cnt++; if (lat !== 4) $display("FAIL eq_slt_lat got %0d exp 4", lat); else pass_cnt++;
        chk_cnt++; if (o_set32 !== 3'b010) $display("FAIL eq_slt_set got %b exp 010", o_set32); else pass_cnt++;
        chk_cnt++; if (o_data32 !== 32'h0) $display("FAIL eq_slt_data got %h exp 0", o_data32); else pass_cnt++;
        release_result();
        issue(1'b0, 64'h1234_5678, 64'h1234_5678, 2'b11, lat);
        chk_cnt++; if (o_data32 !== 32'h1) $display("FAIL eq_sge_data got %h exp 1", o_data32); else pass_cnt++;
        chk_cnt++; if (o_set32 !== 3'b010) $display("FAIL eq_sge_set got %b exp 010", o_set32); else pass_cnt++;
        release_result();
        issue(1'b0, 64'h5, 64'h3, 2'b10, lat);
        chk_cnt++; if (lat !== 4) $display("FAIL sgeu_lat got %0d exp 4", lat); else pass_cnt++;
        chk_cnt++; if (o_data32 !== 32'h1) $display("FAIL sgeu_data got %h exp 1", o_data32); else pass_cnt++;
        chk_cnt++; if (o_set32 !== 3'b001) $display("FAIL sgeu_set got %b exp 001", o_set32); else pass_cnt++;
        release_result();
        issue(1'b0, 64'h0012_0000, 64'h0013_0000, 2'b00, lat);
        chk_cnt++; if (lat !== 2) $display("FAIL two_chunk_lat got %0d exp 2", lat); else pass_cnt++;
        chk_cnt++; if (o_set32 !== 3'b100) $display("FAIL two_chunk_set got %b exp 100", o_set32); else pass_cnt++;
        release_result();
    endtask

    task automatic test_backpressure();
        int lat;
        issue(1'b0, 64'h0, 64'h1, 2'b00, lat);
        chk_cnt++; if (lat !== 4) $display("FAIL bp_lat got %0d exp 4", lat); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            chk_cnt++; if (o_valid32 !== 1'b1) $display("FAIL bp_valid[%0d] got %b exp 1", i, o_valid32); else pass_cnt++;
            chk_cnt++; if (o_data32 !== 32'h1) $display("FAIL bp_data[%0d] got %h exp 1", i, o_data32); else pass_cnt++;
            chk_cnt++; if (o_set32 !== 3'b100) $display("FAIL bp_set[%0d] got %b exp 100", i, o_set32); else pass_cnt++;
            chk_cnt++; if (o_ready32 !== 1'b0) $display("FAIL bp_ready[%0d] got %b exp 0", i, o_ready32); else pass_cnt++;
            if (i == 1) begin v32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'h0; end
            if (i == 2) v32 = 1'b0;
            @(posedge clk); #1;
        end
        rdy = 1'b1;
        @(posedge clk); #1;
        rdy = 1'b0;
        chk_cnt++; if (o_valid32 !== 1'b0) $display("FAIL bp_valid_drop got %b exp 0", o_valid32); else pass_cnt++;
        chk_cnt++; if (o_set32 !== 3'b000) $display("FAIL bp_set_clear got %b exp 000", o_set32); else pass_cnt++;
        chk_cnt++; if (o_ready32 !== 1'b1) $display("FAIL bp_ready_rise got %b exp 1", o_ready32); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk_cnt++; if (o_valid32 !== 1'b0) $display("FAIL bp_ghost_valid[%0d] got %b exp 0", i, o_valid32); else pass_cnt++;
        end
    endtask

    task automatic test_reset_midop();
        mode = 2'b00; a32 = 32'h0; b32 = 32'h1; v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_cnt++; if (o_ready32 !== 1'b0) $display("FAIL rst_mid_ready got %b exp 0", o_ready32); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk_cnt++; if (o_ready32 !== 1'b1) $display("FAIL rst_mid_ready_after got %b exp 1", o_ready32); else pass_cnt++;
        chk_cnt++; if (o_data32 !== 32'h0) $display("FAIL rst_mid_data got %h exp 0", o_data32); else pass_cnt++;
        chk_cnt++; if (o_set32 !== 3'b000) $display("FAIL rst_mid_set got %b exp 000", o_set32); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            chk_cnt++; if (o_valid32 !== 1'b0) $display("FAIL rst_mid_valid[%0d] got %b exp 0", i, o_valid32); else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wide();
        int lat;
        issue(1'b1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 2'b01, lat);
        chk_cnt++; if (lat !== 1) $display("FAIL w64_slt_lat got %0d exp 1", lat); else pass_cnt++;
        chk_cnt++; if (o_data64 !== 64'h1) $display("FAIL w64_slt_data got %h exp 1", o_data64); else pass_cnt++;
        chk_cnt++; if (o_set64 !== 3'b100) $display("FAIL w64_slt_set got %b exp 100", o_set64); else pass_cnt++;
        release_result();
        issue(1'b1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 2'b00, lat);
        chk_cnt++; if (lat !== 1) $display("FAIL w64_sltu_lat got %0d exp 1", lat); else pass_cnt++;
        chk_cnt++; if (o_data64 !== 64'h0) $display("FAIL w64_sltu_data got %h exp 0", o_data64); else pass_cnt++;
        chk_cnt++; if (o_set64 !== 3'b001) $display("FAIL w64_sltu_set got %b exp 001", o_set64); else pass_cnt++;
        release_result();
    endtask

    initial begin
        test_reset();
        test_sltu_slt();
        test_equal_and_ge();
        test_backpressure();
        test_reset_midop();
        test_wide();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
